magic_nor_engine: RTL and testbench
===================================

// Module: magic_nor_engine
// PURPOSE
//  Programmable MAGIC-style NOR netlist evaluator. A NOR-only netlist is loaded
//  into gate memory; each evaluation computes one 2-input NOR per cycle into a
//  fresh cell. This is the serial in-memory compute model, generalised in input
//  count, gate depth and output count. Sits between the host input stream and
//  the result stream.
// PARAMETERS
//  NUM_IN     4   primary inputs; occupy cells 0..NUM_IN-1
//  MAX_GATES  32  gate memory depth; gate i writes cell NUM_IN+i
//  NUM_OUT    1   outputs; each taken from a programmable cell index
//  CELL_W     $clog2(NUM_IN+MAX_GATES)  cell index width (derived)
//  GC_W       $clog2(MAX_GATES+1)       gate-count width (derived)
// PORTS
//  clk         in   1               clock, rising edge
//  rst_n       in   1               asynchronous active-low reset
//  prog_we     in   1               program write strobe
//  prog_addr   in   $clog2(MAX_GATES+NUM_OUT)  <MAX_GATES: gate entry; else out-map entry
//  prog_data   in   2*CELL_W        gate: {src_a,src_b}; out-map: low CELL_W = cell index
//  gate_count  in   GC_W            gates to execute, sampled on input accept
//  in_valid    in   1               input vector valid
//  in_ready    out  1               engine can accept inputs
//  in_data     in   NUM_IN          primary input vector, bit k -> cell k
//  out_valid   out  1               result valid
//  out_ready   in   1               consumer accepts result
//  out_data    out  NUM_OUT         result bits, bit j = cell[outmap[j]]
//  err         out  1               sticky: illegal source reference seen in this evaluation
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1, out_valid=0, out_data=0, err=0; all cells 0;
//    gate and out-map memories NOT reset (contents undefined until programmed).
//  - States: IDLE -> EXEC -> DONE -> IDLE.
//  - IDLE: prog_we=1 writes entry; prog_we has priority, so in_ready=0 in that cycle.
//    Accept on in_valid&in_ready: load cells[0..NUM_IN-1], latch gate_count
//    (clamped to MAX_GATES), clear err, gate index g=0.
//    If count==0: go directly to DONE; else go to EXEC.
//  - EXEC: one gate per cycle: cell[NUM_IN+g] = ~(cell[src_a] | cell[src_b]).
//    NOT = NOR with src_a==src_b. A source index >= NUM_IN+g (forward or
//    out-of-range reference) reads as 0 and sets err. After gate count-1 -> DONE.
//  - DONE: out_data registered from out-map on entry; out_valid=1 held until
//    out_ready; on handshake return to IDLE (out_data held, out_valid=0).
//  - Latency: accept edge to out_valid = count+1 cycles (1 if count==0).
//  - in_ready=1 only in IDLE with prog_we=0. prog_we outside IDLE is ignored.
//  - An out-map index >= NUM_IN+count selects a stale/zero cell; no err is raised.
//  - Cells above NUM_IN+count-1 retain stale values; they are not cleared between runs.
//  - rst_n low mid-EXEC/DONE: immediate return to reset values. The result is lost;
//    program memories are retained.
// CONFIGURATION
//  MAGIC_SWITCH_CNT_EN defined: adds output sw_cnt [15:0], cleared on accept.
//    It increments for each executed gate whose result is 0 (a memristor switch
//    from the initialised 1 state). It saturates at 16'hFFFF and is valid with
//    out_valid. Reset value is 0.
//  Undefined: the port and counter are absent; all other behaviour is identical.
// TESTING
//  1. Reset: rst_n=0 -> in_ready=1, out_valid=0, out_data=0, err=0.
//  2. XOR program: NUM_IN=4; g0=(0,1) g1=(0,4) g2=(1,4) g3=(5,6) g4=(7,7);
//     out0=cell 8, count=5. For in_data=4'b0001 -> out_data=1 after 6 cycles;
//     for in_data=4'b0011 -> out_data=0; err=0.
//  3. count=0, out0=cell 2, in_data=4'b0100 -> out_valid next cycle, out_data=1.
//  4. g0=(0,9), count=1 -> err=1; source read as 0; out = ~x0.
//  5. Backpressure: hold out_ready=0 for 10 cycles -> out_valid and out_data stable,
//     in_ready=0. Same cycle: in_valid with prog_we in IDLE -> write done, no accept.
//  6. Assert rst_n mid-EXEC -> out_valid=0, in_ready=1; rerun test 2 without
//     reprogramming -> same result. With MAGIC_SWITCH_CNT_EN, test 2 x=0001 -> sw_cnt=3.

Source files
------------

// File: rtl/magic_nor_if.sv
// Host-side bus of the MAGIC NOR engine: program port, input stream and result stream.
// With MAGIC_SWITCH_CNT_EN defined, the bus also carries the switch counter.
interface magic_nor_if #(
    parameter int unsigned NUM_IN    = 4,
    parameter int unsigned MAX_GATES = 32,
    parameter int unsigned NUM_OUT   = 1
);
    localparam int unsigned CELL_W = $clog2(NUM_IN + MAX_GATES);
    localparam int unsigned GC_W   = $clog2(MAX_GATES + 1);
    localparam int unsigned PA_W   = $clog2(MAX_GATES + NUM_OUT);

    logic                  prog_we;
    logic [PA_W-1:0]       prog_addr;
    logic [2*CELL_W-1:0]   prog_data;
    logic [GC_W-1:0]       gate_count;
    logic                  in_valid;
    logic                  in_ready;
    logic [NUM_IN-1:0]     in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [NUM_OUT-1:0]    out_data;
    logic                  err;
`ifdef MAGIC_SWITCH_CNT_EN
    logic [15:0]           sw_cnt;

    modport master (
        output prog_we, prog_addr, prog_data, gate_count, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, err, sw_cnt
    );
    modport slave (
        input  prog_we, prog_addr, prog_data, gate_count, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, err, sw_cnt
    );
`else
    modport master (
        output prog_we, prog_addr, prog_data, gate_count, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, err
    );
    modport slave (
        input  prog_we, prog_addr, prog_data, gate_count, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, err
    );
`endif
endinterface

// File: rtl/magic_nor_engine.sv
// Serial NOR-netlist evaluator: one programmable 2-input NOR per cycle into a fresh cell.
// Optional MAGIC_SWITCH_CNT_EN adds a saturating count of gates that evaluated to 0.
module magic_nor_engine #(
    parameter int unsigned NUM_IN    = 4,
    parameter int unsigned MAX_GATES = 32,
    parameter int unsigned NUM_OUT   = 1
) (
    input logic        clk,
    input logic        rst_n,
    magic_nor_if.slave bus
);
    localparam int unsigned NCELL  = NUM_IN + MAX_GATES;
    localparam int unsigned CELL_W = $clog2(NCELL);
    localparam int unsigned GC_W   = $clog2(MAX_GATES + 1);
    localparam int unsigned GI_W   = (MAX_GATES > 1) ? $clog2(MAX_GATES) : 1;
    localparam int unsigned OI_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [NCELL-1:0]    cells_q, cells_d;
    logic [GC_W-1:0]     g_q, g_d;
    logic [GC_W-1:0]     cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                ov_q, ov_d;
    logic [NUM_OUT-1:0]  od_q, od_d;
`ifdef MAGIC_SWITCH_CNT_EN
    logic [15:0]         sw_q, sw_d;
`endif

    logic [2*CELL_W-1:0] gate_mem [MAX_GATES];
    logic [CELL_W-1:0]   out_map  [NUM_OUT];

    logic [CELL_W-1:0]   src_a, src_b, lim;
    logic                val_a, val_b, nor_r, load_out;

    // Program memories are intentionally not reset; they survive rst_n.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && bus.prog_we) begin
            if (32'(bus.prog_addr) < MAX_GATES)
                gate_mem[GI_W'(bus.prog_addr)] <= bus.prog_data;
            else if (32'(bus.prog_addr) - MAX_GATES < NUM_OUT)
                out_map[OI_W'(32'(bus.prog_addr) - MAX_GATES)] <= bus.prog_data[CELL_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cells_q <= '0;
            g_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
`ifdef MAGIC_SWITCH_CNT_EN
            sw_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cells_q <= cells_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
`ifdef MAGIC_SWITCH_CNT_EN
            sw_q    <= sw_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cells_d  = cells_q;
        g_d      = g_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ov_d     = ov_q;
        od_d     = od_q;
`ifdef MAGIC_SWITCH_CNT_EN
        sw_d     = sw_q;
`endif
        load_out = 1'b0;
        src_a    = gate_mem[GI_W'(g_q)][2*CELL_W-1:CELL_W];
        src_b    = gate_mem[GI_W'(g_q)][CELL_W-1:0];
        lim      = CELL_W'(NUM_IN) + CELL_W'(g_q);
        val_a    = 1'b0;
        val_b    = 1'b0;
        nor_r    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.prog_we && bus.in_valid) begin
                    cells_d[NUM_IN-1:0] = bus.in_data;
                    cnt_d = (bus.gate_count > GC_W'(MAX_GATES)) ? GC_W'(MAX_GATES) : bus.gate_count;
                    err_d = 1'b0;
                    g_d   = '0;
`ifdef MAGIC_SWITCH_CNT_EN
                    sw_d  = '0;
`endif
                    if (cnt_d == '0) begin
                        state_d  = S_DONE;
                        ov_d     = 1'b1;
                        load_out = 1'b1;
                    end else begin
                        state_d  = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                // Sources not yet computed (or past the cell array) read as 0 and flag err.
                if (src_a < lim) val_a = cells_q[src_a];
                else             err_d = 1'b1;
                if (src_b < lim) val_b = cells_q[src_b];
                else             err_d = 1'b1;
                nor_r        = ~(val_a | val_b);
                cells_d[lim] = nor_r;
`ifdef MAGIC_SWITCH_CNT_EN
                if (!nor_r && sw_q != 16'hFFFF) sw_d = sw_q + 16'd1;
`endif
                g_d = g_q + GC_W'(1);
                if (g_q == cnt_q - GC_W'(1)) begin
                    state_d  = S_DONE;
                    ov_d     = 1'b1;
                    load_out = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    ov_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Result is taken from the post-update cells so the final gate is visible.
        if (load_out) begin
            for (int j = 0; j < NUM_OUT; j++)
                od_d[j] = (32'(out_map[j]) < NCELL) ? cells_d[out_map[j]] : 1'b0;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !bus.prog_we;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.err       = err_q;
`ifdef MAGIC_SWITCH_CNT_EN
    assign bus.sw_cnt    = sw_q;
`endif

endmodule

// File: tb/tb_magic_nor_engine.sv
// Bench for magic_nor_engine: directed scenarios plus random netlists against a cell-array model.
module tb_magic_nor_engine;
    localparam int NUM_IN    = 4;
    localparam int MAX_GATES = 32;
    localparam int NUM_OUT   = 1;
    localparam int NCELL     = NUM_IN + MAX_GATES;
    localparam int CELL_W    = $clog2(NCELL);
    localparam int PA_W      = $clog2(MAX_GATES + NUM_OUT);
    localparam int GC_W      = $clog2(MAX_GATES + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    magic_nor_if #(.NUM_IN(NUM_IN), .MAX_GATES(MAX_GATES), .NUM_OUT(NUM_OUT)) bus();
    magic_nor_engine #(.NUM_IN(NUM_IN), .MAX_GATES(MAX_GATES), .NUM_OUT(NUM_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: netlist tables and a persistent cell array.
    int                 m_sa [MAX_GATES];
    int                 m_sb [MAX_GATES];
    int                 m_omap [NUM_OUT];
    bit                 m_cell [NCELL];
    logic [NUM_OUT-1:0] m_out;
    logic               m_err;
    int                 m_sw;

    task automatic model_clear();
        for (int k = 0; k < NCELL; k++) m_cell[k] = 1'b0;
    endtask

    task automatic model_eval(input logic [NUM_IN-1:0] x, input int cnt);
        int n;
        bit a, b, r;
        n     = (cnt > MAX_GATES) ? MAX_GATES : cnt;
        m_err = 1'b0;
        m_sw  = 0;
        for (int k = 0; k < NUM_IN; k++) m_cell[k] = x[k];
        for (int g = 0; g < n; g++) begin
            if (m_sa[g] < NUM_IN + g) a = m_cell[m_sa[g]]; else begin a = 0; m_err = 1'b1; end
            if (m_sb[g] < NUM_IN + g) b = m_cell[m_sb[g]]; else begin b = 0; m_err = 1'b1; end
            r = !(a || b);
            m_cell[NUM_IN + g] = r;
            if (!r && m_sw < 65535) m_sw++;
        end
        for (int j = 0; j < NUM_OUT; j++)
            m_out[j] = (m_omap[j] < NCELL) ? m_cell[m_omap[j]] : 1'b0;
    endtask

    // All stimulus tasks start and end just after a falling edge.
    task automatic prog(input int addr, input int data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = PA_W'(addr);
        bus.prog_data = (2*CELL_W)'(data);
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    task automatic prog_gate(input int g, input int a, input int b);
        prog(g, (a << CELL_W) | b);
        m_sa[g] = a;
        m_sb[g] = b;
    endtask

    task automatic prog_out(input int j, input int c);
        prog(MAX_GATES + j, c);
        m_omap[j] = c;
    endtask

    task automatic run_eval(input logic [NUM_IN-1:0] x, input int cnt, input bit release_out,
                            output logic [NUM_OUT-1:0] o, output logic e,
                            output logic [15:0] sw, output int lat);
        bus.in_valid   = 1'b1;
        bus.in_data    = x;
        bus.gate_count = GC_W'(cnt);
        @(negedge clk);
        bus.in_valid   = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        o = bus.out_data;
        e = bus.err;
`ifdef MAGIC_SWITCH_CNT_EN
        sw = bus.sw_cnt;
`else
        sw = 16'd0;
`endif
        if (release_out) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.gate_count = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %b want 0", bus.out_data); end
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.err); end
`ifdef MAGIC_SWITCH_CNT_EN
        n_cmp++; if (bus.sw_cnt !== 16'd0) begin n_err++; $display("FAIL reset_sw_cnt: got %0d want 0", bus.sw_cnt); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_xor(input string tag);
        logic [NUM_IN-1:0]  xs [2];
        logic [NUM_OUT-1:0] o;
        logic               e;
        logic [15:0]        sw;
        int                 lat;
        xs[0] = 4'b0001;
        xs[1] = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            model_eval(xs[i], 5);
            run_eval(xs[i], 5, 1'b1, o, e, sw, lat);
            n_cmp++; if (o !== NUM_OUT'(xs[i][0] ^ xs[i][1])) begin n_err++; $display("FAIL %s_out x=%b: got %b want %b", tag, xs[i], o, xs[i][0] ^ xs[i][1]); end
            n_cmp++; if (o !== m_out) begin n_err++; $display("FAIL %s_model x=%b: got %b want %b", tag, xs[i], o, m_out); end
            n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL %s_err x=%b: got %b want 0", tag, xs[i], e); end
            n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL %s_latency x=%b: got %0d want 6", tag, xs[i], lat); end
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL %s_release: out_valid got %b want 0", tag, bus.out_valid); end
`ifdef MAGIC_SWITCH_CNT_EN
            n_cmp++; if (int'(sw) !== m_sw) begin n_err++; $display("FAIL %s_sw_cnt x=%b: got %0d want %0d", tag, xs[i], sw, m_sw); end
            if (i == 0) begin
                n_cmp++; if (sw !== 16'd3) begin n_err++; $display("FAIL %s_sw_cnt_3: got %0d want 3", tag, sw); end
            end
`endif
        end
    endtask

    task automatic test_xor();
        prog_gate(0, 0, 1);
        prog_gate(1, 0, 4);
        prog_gate(2, 1, 4);
        prog_gate(3, 5, 6);
        prog_gate(4, 7, 7);
        prog_out(0, 8);
        check_xor("xor");
    endtask

    task automatic test_reset_mid_exec();
        bus.in_valid   = 1'b1;
        bus.in_data    = 4'b0001;
        bus.gate_count = GC_W'(5);
        @(negedge clk);
        bus.in_valid   = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL midrst_err: got %b want 0", bus.err); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        check_xor("rerun");
    endtask

    task automatic test_count_zero();
        logic [NUM_OUT-1:0] o;
        logic e;
        logic [15:0] sw;
        int lat;
        prog_out(0, 2);
        model_eval(4'b0100, 0);
        run_eval(4'b0100, 0, 1'b1, o, e, sw, lat);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL cnt0_latency: got %0d want 1", lat); end
        n_cmp++; if (o !== 1'b1) begin n_err++; $display("FAIL cnt0_out: got %b want 1", o); end
        n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL cnt0_err: got %b want 0", e); end
`ifdef MAGIC_SWITCH_CNT_EN
        n_cmp++; if (sw !== 16'd0) begin n_err++; $display("FAIL cnt0_sw_cnt: got %0d want 0", sw); end
`endif
    endtask

    task automatic test_err();
        logic [NUM_OUT-1:0] o;
        logic e;
        logic [15:0] sw;
        int lat;
        logic [NUM_IN-1:0] x;
        prog_gate(0, 0, 9);
        prog_out(0, 4);
        for (int i = 0; i < 2; i++) begin
            x = (i == 0) ? 4'b0001 : 4'b1110;
            model_eval(x, 1);
            run_eval(x, 1, 1'b1, o, e, sw, lat);
            n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL fwdref_err x=%b: got %b want 1", x, e); end
            n_cmp++; if (o !== NUM_OUT'(~x[0])) begin n_err++; $display("FAIL fwdref_out x=%b: got %b want %b", x, o, ~x[0]); end
            n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL fwdref_latency x=%b: got %0d want 2", x, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [NUM_OUT-1:0] o, o2;
        logic e;
        logic [15:0] sw;
        int lat;
        prog_gate(0, 0, 1);
        prog_out(0, 8);
        model_eval(4'b0010, 5);
        run_eval(4'b0010, 5, 1'b0, o, e, sw, lat);
        n_cmp++; if (o !== m_out) begin n_err++; $display("FAIL bp_out: got %b want %b", o, m_out); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== o || bus.in_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_hold cyc=%0d: valid/data/ready got %b/%b/%b want 1/%b/0", c, bus.out_valid, bus.out_data, bus.in_ready, o);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", bus.out_valid); end
        // Program write and input offer in the same IDLE cycle: the write wins.
        bus.prog_we    = 1'b1;
        bus.prog_addr  = PA_W'(MAX_GATES);
        bus.prog_data  = (2*CELL_W)'(7);
        bus.in_valid   = 1'b1;
        bus.in_data    = 4'b0001;
        bus.gate_count = GC_W'(5);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL collide_in_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        bus.prog_we  = 1'b0;
        bus.in_valid = 1'b0;
        m_omap[0]    = 7;
        repeat (8) @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL collide_no_accept: valid/ready got %b/%b want 0/1", bus.out_valid, bus.in_ready);
        end
        model_eval(4'b0011, 5);
        run_eval(4'b0011, 5, 1'b1, o2, e, sw, lat);
        n_cmp++; if (o2 !== 1'b1 || o2 !== m_out) begin n_err++; $display("FAIL collide_write: got %b want 1 (model %b)", o2, m_out); end
    endtask

    task automatic test_random();
        logic [NUM_OUT-1:0] o;
        logic e;
        logic [15:0] sw;
        int lat, cnt, a, b, exp_lat;
        logic [NUM_IN-1:0] x;
        for (int it = 0; it < 30; it++) begin
            if (it % 6 == 0) begin
                for (int g = 0; g < MAX_GATES; g++) begin
                    a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, NUM_IN + g - 1));
                    b = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, NUM_IN + g - 1));
                    prog_gate(g, a, b);
                end
                for (int j = 0; j < NUM_OUT; j++)
                    prog_out(j, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, NCELL - 1)));
            end
            cnt = int'($urandom_range(0, 40));
            x   = NUM_IN'($urandom);
            exp_lat = ((cnt > MAX_GATES) ? MAX_GATES : cnt) + 1;
            model_eval(x, cnt);
            run_eval(x, cnt, 1'b1, o, e, sw, lat);
            n_cmp++; if (o !== m_out || e !== m_err || lat !== exp_lat) begin
                n_err++; $display("FAIL rand it=%0d cnt=%0d x=%b: out/err/lat got %b/%b/%0d want %b/%b/%0d", it, cnt, x, o, e, lat, m_out, m_err, exp_lat);
            end
`ifdef MAGIC_SWITCH_CNT_EN
            n_cmp++; if (int'(sw) !== m_sw) begin n_err++; $display("FAIL rand_sw_cnt it=%0d: got %0d want %0d", it, sw, m_sw); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_reset_mid_exec();
        test_count_zero();
        test_err();
        test_backpressure();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
